// File: rtl/sound_sequencer.sv
// Sound event scheduler: latches collision/move requests, plays them one at a time
// on the shared oscillator in fixed priority (bad > good > move), and owns the mute state.
module sound_sequencer #(
    parameter int DUR       = 25,
    parameter int GAP       = 5,
    parameter int FW        = 8,
    parameter int FREQ_BAD  = 126,
    parameter int FREQ_GOOD = 89,
    parameter int FREQ_MOVE = 149
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          good_req,
    input  logic          bad_req,
    input  logic          move_req,
    input  logic          mute_toggle,
    output logic [FW-1:0] freq,
    output logic          play,
    output logic [1:0]    active_src,
    output logic [2:0]    pending,
    output logic          muted,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, TONE, GAP_S} state_t;

    localparam logic [FW-1:0] F_BAD    = FW'(FREQ_BAD);
    localparam logic [FW-1:0] F_GOOD   = FW'(FREQ_GOOD);
    localparam logic [FW-1:0] F_MOVE   = FW'(FREQ_MOVE);
    localparam logic [7:0]    DUR_LOAD = 8'(DUR - 1);
    localparam logic [7:0]    GAP_LOAD = 8'(GAP - 1);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_MOVE = 2'b01;
    localparam logic [1:0] SRC_GOOD = 2'b10;
    localparam logic [1:0] SRC_BAD  = 2'b11;

    state_t        state_reg, state_next;
    logic [7:0]    counter_reg, counter_next;
    logic [FW-1:0] freq_next;
    logic          play_next;
    logic [1:0]    src_next;
    logic          busy_next;
    logic [2:0]    pending_next;
    logic [2:0]    req_vec;
    logic [2:0]    grant_vec;
    logic          clear_all;

    assign req_vec   = {bad_req, good_req, move_req};
    // Muted (or about to toggle mute) means no request may survive.
    assign clear_all = muted | mute_toggle;

    // A grant wins over a same-cycle request of the same source, absorbing it.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pend
            assign pending_next[gi] = !clear_all && !grant_vec[gi] &&
                                      (pending[gi] || req_vec[gi]);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        freq_next    = freq;
        play_next    = play;
        src_next     = active_src;
        busy_next    = busy;
        grant_vec    = 3'b000;

        if (mute_toggle) begin
            state_next   = IDLE;
            counter_next = 8'd0;
            freq_next    = '0;
            play_next    = 1'b0;
            src_next     = SRC_NONE;
            busy_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!muted && pending != 3'b000) begin
                        state_next   = TONE;
                        counter_next = DUR_LOAD;
                        play_next    = 1'b1;
                        busy_next    = 1'b1;
                        if (pending[2]) begin
                            grant_vec = 3'b100;
                            freq_next = F_BAD;
                            src_next  = SRC_BAD;
                        end else if (pending[1]) begin
                            grant_vec = 3'b010;
                            freq_next = F_GOOD;
                            src_next  = SRC_GOOD;
                        end else begin
                            grant_vec = 3'b001;
                            freq_next = F_MOVE;
                            src_next  = SRC_MOVE;
                        end
                    end
                end
                TONE: begin
                    // A bad collision cuts any other tone short; the cut tone is dropped.
                    if (pending[2] && active_src != SRC_BAD) begin
                        grant_vec    = 3'b100;
                        freq_next    = F_BAD;
                        src_next     = SRC_BAD;
                        counter_next = DUR_LOAD;
                    end else if (counter_reg == 8'd0) begin
                        state_next   = GAP_S;
                        play_next    = 1'b0;
                        counter_next = GAP_LOAD;
                    end else begin
                        counter_next = counter_reg - 8'd1;
                    end
                end
                GAP_S: begin
                    if (counter_reg == 8'd0) begin
                        state_next = IDLE;
                        freq_next  = '0;
                        src_next   = SRC_NONE;
                        busy_next  = 1'b0;
                    end else begin
                        counter_next = counter_reg - 8'd1;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    counter_next = 8'd0;
                    freq_next    = '0;
                    play_next    = 1'b0;
                    src_next     = SRC_NONE;
                    busy_next    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            counter_reg <= 8'd0;
            freq        <= '0;
            play        <= 1'b0;
            active_src  <= SRC_NONE;
            pending     <= 3'b000;
            muted       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            freq        <= freq_next;
            play        <= play_next;
            active_src  <= src_next;
            pending     <= pending_next;
            muted       <= muted ^ mute_toggle;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench: stimulus queues expected tones (freq, source, start cycle, length);
// a negedge monitor reconstructs tones from the play/active_src outputs and compares.
module tb_sound_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       good_req = 1'b0;
    logic       bad_req = 1'b0;
    logic       move_req = 1'b0;
    logic       mute_toggle = 1'b0;
    logic [7:0] freq;
    logic       play;
    logic [1:0] active_src;
    logic [2:0] pending;
    logic       muted;
    logic       busy;

    sound_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .good_req   (good_req),
        .bad_req    (bad_req),
        .move_req   (move_req),
        .mute_toggle(mute_toggle),
        .freq       (freq),
        .play       (play),
        .active_src (active_src),
        .pending    (pending),
        .muted      (muted),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int f;
        int s;
        int start;
        int len;
    } tone_t;

    tone_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_tone(input int f, input int s, input int start, input int len);
        tone_t e;
        e.f = f; e.s = s; e.start = start; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic drive(input logic b, input logic g, input logic m, input logic mt);
        bad_req = b; good_req = g; move_req = m; mute_toggle = mt;
        tick(1);
        bad_req = 1'b0; good_req = 1'b0; move_req = 1'b0; mute_toggle = 1'b0;
    endtask

    // Monitor
    logic       prev_play = 1'b0;
    logic [7:0] prev_freq = 8'd0;
    logic [1:0] prev_src = 2'd0;
    int         tone_start = 0;

    task automatic report_tone(input int f, input int s, input int start, input int len);
        tone_t e;
        checks++;
        $display("tone freq=%0d src=%0d start=%0d len=%0d", f, s, start, len);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tone: got freq=%0d src=%0d start=%0d len=%0d required none",
                     f, s, start, len);
        end else begin
            e = exp_q.pop_front();
            if (e.f != f || e.s != s || e.start != start || e.len != len) begin
                errors++;
                $display("FAIL tone: got freq=%0d src=%0d start=%0d len=%0d required freq=%0d src=%0d start=%0d len=%0d",
                         f, s, start, len, e.f, e.s, e.start, e.len);
            end
        end
    endtask

    always @(negedge clk) begin
        if (prev_play && (!play || active_src != prev_src))
            report_tone(int'(prev_freq), int'(prev_src), tone_start, cyc - tone_start);
        if (play && (!prev_play || active_src != prev_src))
            tone_start = cyc;
        prev_play = play;
        prev_freq = freq;
        prev_src  = active_src;
    end

    int t;

    initial begin
        // Reset state
        tick(3);
        check("rst_freq", freq, 0);
        check("rst_play", play, 0);
        check("rst_src", active_src, 0);
        check("rst_pending", pending, 0);
        check("rst_muted", muted, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        // 1: single good request, tone then gap then idle
        t = cyc;
        push_tone(89, 2, t + 2, 25);
        drive(0, 1, 0, 0);
        check("s1_pending", pending, 3'b010);
        check("s1_busy_idle", busy, 0);
        wait_until(t + 2);
        check("s1_busy_tone", busy, 1);
        wait_until(t + 30);
        check("s1_gap_freq", freq, 89);
        check("s1_gap_play", play, 0);
        check("s1_gap_busy", busy, 1);
        wait_until(t + 32);
        check("s1_idle_freq", freq, 0);
        check("s1_idle_busy", busy, 0);
        check("s1_idle_src", active_src, 0);

        // 2: all three at once, priority order
        t = cyc;
        push_tone(126, 3, t + 2, 25);
        push_tone(89, 2, t + 33, 25);
        push_tone(149, 1, t + 64, 25);
        drive(1, 1, 1, 0);
        check("s2_pend111", pending, 3'b111);
        wait_until(t + 2);
        check("s2_pend011", pending, 3'b011);
        wait_until(t + 33);
        check("s2_pend001", pending, 3'b001);
        wait_until(t + 64);
        check("s2_pend000", pending, 3'b000);
        wait_until(t + 100);

        // 3: bad preempts a move tone without a gap
        t = cyc;
        push_tone(149, 1, t + 2, 11);
        push_tone(126, 3, t + 13, 25);
        drive(0, 0, 1, 0);
        wait_until(t + 11);
        drive(1, 0, 0, 0);
        check("s3_pend_bad", pending, 3'b100);
        wait_until(t + 13);
        check("s3_freq", freq, 126);
        check("s3_play", play, 1);
        check("s3_pend_clear", pending, 3'b000);
        wait_until(t + 50);

        // 4: mute aborts tone and clears pending; unmute restores operation
        t = cyc;
        push_tone(89, 2, t + 2, 9);
        push_tone(89, 2, t + 27, 25);
        drive(0, 1, 0, 0);
        wait_until(t + 8);
        drive(0, 1, 0, 0);
        check("s4_pend_good", pending, 3'b010);
        wait_until(t + 10);
        drive(0, 0, 0, 1);
        check("s4_mute_play", play, 0);
        check("s4_mute_pend", pending, 3'b000);
        check("s4_muted", muted, 1);
        check("s4_mute_busy", busy, 0);
        wait_until(t + 13);
        drive(0, 1, 1, 0);
        check("s4_ignored_pend", pending, 3'b000);
        tick(1);
        check("s4_ignored_play", play, 0);
        wait_until(t + 22);
        drive(0, 0, 0, 1);
        check("s4_unmuted", muted, 0);
        wait_until(t + 25);
        drive(0, 1, 0, 0);
        wait_until(t + 60);

        // 5: held move request, grant-cycle request absorbed, later one re-queued
        t = cyc;
        push_tone(149, 1, t + 2, 25);
        push_tone(149, 1, t + 33, 25);
        move_req = 1'b1;
        tick(1);
        check("s5_pend_set", pending, 3'b001);
        tick(1);
        check("s5_absorbed", pending, 3'b000);
        check("s5_play", play, 1);
        tick(1);
        move_req = 1'b0;
        check("s5_requeued", pending, 3'b001);
        wait_until(t + 33);
        check("s5_pend_done", pending, 3'b000);
        wait_until(t + 70);

        // 6: asynchronous reset mid-gap with a pending request
        t = cyc;
        push_tone(89, 2, t + 2, 25);
        drive(0, 1, 0, 0);
        wait_until(t + 27);
        drive(0, 0, 1, 0);
        wait_until(t + 29);
        check("s6_pre_pend", pending, 3'b001);
        check("s6_pre_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("s6_async_freq", freq, 0);
        check("s6_async_busy", busy, 0);
        check("s6_async_pend", pending, 0);
        check("s6_async_src", active_src, 0);
        #2 rst = 1'b0;
        tick(2);
        t = cyc;
        push_tone(149, 1, t + 2, 25);
        drive(0, 0, 1, 0);
        wait_until(t + 40);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
